// File: rtl/decode_pkg.sv
// Shared defaults for the decode stage: field widths, the load flag position and the ID/EX
// record layout that EX-side blocks use when they run at the default widths.
package decode_pkg;

    localparam int DATA_W_D     = 32;
    localparam int PC_W_D       = 48;
    localparam int RA_W_D       = 5;
    localparam int OPC_W_D      = 6;
    localparam int ALU_FW_D     = 4;
    localparam int MEM_FW_D     = 3;
    localparam int WB_FW_D      = 2;
    localparam int MEM_RD_BIT_D = 0;
    localparam int CNT_W_D      = 16;

    typedef struct packed {
        logic                valid;
        logic [PC_W_D-1:0]   pc1;
        logic [OPC_W_D-1:0]  opcode;
        logic [DATA_W_D-1:0] immediate;
        logic [RA_W_D-1:0]   rd;
        logic [ALU_FW_D-1:0] flags_alu;
        logic [MEM_FW_D-1:0] flags_mem;
        logic [WB_FW_D-1:0]  flags_wb;
        logic [DATA_W_D-1:0] data_one;
        logic [DATA_W_D-1:0] data_two;
    } idex_t;

    // A bubble is an all-zero record: not valid and no side-effecting flags.
    localparam idex_t BUBBLE = '0;

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file with two operand read ports, one debug read port and a single write port.
// Reads see a same-cycle write (write-through bypass); the whole array clears on reset.
module reg_file_2r1w #(
    parameter int DATA_W   = 32,
    parameter int RA_W     = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [RA_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RA_W-1:0]   raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [RA_W-1:0]   raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [RA_W-1:0]   raddr_dbg_i,
    output logic [DATA_W-1:0] rdata_dbg_o
);

    localparam int NREG = 2 ** RA_W;

    logic [DATA_W-1:0] mem_q [NREG];
    logic              wr_en;

    // A write to a hard-wired zero register is dropped and never bypassed.
    assign wr_en = we_i && !((ZERO_REG != 0) && (waddr_i == '0));

    function automatic logic [DATA_W-1:0] read_port(input logic [RA_W-1:0] addr);
        if ((ZERO_REG != 0) && (addr == '0))
            return '0;
        else if (wr_en && (waddr_i == addr))
            return wdata_i;
        else
            return mem_q[addr];
    endfunction

    assign rdata_a_o   = read_port(raddr_a_i);
    assign rdata_b_o   = read_port(raddr_b_i);
    assign rdata_dbg_o = read_port(raddr_dbg_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// ID stage: operand read, load-use hazard detection and the registered ID/EX boundary.
// Valid/ready: IF/ID holds its instruction while stall is high; EX consumes whenever out_valid is set.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W     = DATA_W_D,
    parameter int PC_W       = PC_W_D,
    parameter int RA_W       = RA_W_D,
    parameter int OPC_W      = OPC_W_D,
    parameter int ALU_FW     = ALU_FW_D,
    parameter int MEM_FW     = MEM_FW_D,
    parameter int WB_FW      = WB_FW_D,
    parameter int MEM_RD_BIT = MEM_RD_BIT_D,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = CNT_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   pc1,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [RA_W-1:0]   rd,
    input  logic [RA_W-1:0]   rs,
    input  logic [RA_W-1:0]   rt,
    input  logic              uses_rt,
    input  logic [DATA_W-1:0] immediate,
    input  logic              flags_deco,
    input  logic [ALU_FW-1:0] flags_alu,
    input  logic [MEM_FW-1:0] flags_mem,
    input  logic [WB_FW-1:0]  flags_wb,
    input  logic [RA_W-1:0]   wb_dir,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_we,
    input  logic              flush,
    output logic              stall,
    output logic              out_valid,
    output logic [PC_W-1:0]   pc1_out,
    output logic [OPC_W-1:0]  opcode_out,
    output logic [DATA_W-1:0] immediate_out,
    output logic [RA_W-1:0]   rd_out,
    output logic [ALU_FW-1:0] flags_alu_out,
    output logic [MEM_FW-1:0] flags_mem_out,
    output logic [WB_FW-1:0]  flags_wb_out,
    output logic [DATA_W-1:0] data_one,
    output logic [DATA_W-1:0] data_two,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q;
    logic [PC_W-1:0]   pc1_q;
    logic [OPC_W-1:0]  opcode_q;
    logic [DATA_W-1:0] imm_q;
    logic [RA_W-1:0]   rd_q;
    logic [ALU_FW-1:0] falu_q;
    logic [MEM_FW-1:0] fmem_q;
    logic [WB_FW-1:0]  fwb_q;
    logic [DATA_W-1:0] d1_q, d2_q;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;

    reg_file_2r1w #(.DATA_W(DATA_W), .RA_W(RA_W), .ZERO_REG(ZERO_REG)) u_rf (
        .clk         (clk),
        .rst         (rst),
        .we_i        (wb_we),
        .waddr_i     (wb_dir),
        .wdata_i     (wb_data),
        .raddr_a_i   (rs),
        .rdata_a_o   (rdata_a),
        .raddr_b_i   (rt),
        .rdata_b_o   (rdata_b),
        .raddr_dbg_i (dbg_addr),
        .rdata_dbg_o (dbg_data)
    );

    // A load sitting in ID/EX whose destination feeds this instruction cannot be forwarded yet.
    assign hazard = in_valid && valid_q && fmem_q[MEM_RD_BIT] && (rd_q != '0) &&
                    ((rd_q == rs) || (uses_rt && (rd_q == rt)));
    assign stall  = hazard && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst || flush || stall) begin
            valid_q  <= 1'b0;
            pc1_q    <= '0;
            opcode_q <= '0;
            imm_q    <= '0;
            rd_q     <= '0;
            falu_q   <= '0;
            fmem_q   <= '0;
            fwb_q    <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
        end else begin
            valid_q  <= in_valid;
            pc1_q    <= pc1;
            opcode_q <= opcode;
            imm_q    <= immediate;
            rd_q     <= rd;
            falu_q   <= in_valid ? flags_alu : '0;
            fmem_q   <= in_valid ? flags_mem : '0;
            fwb_q    <= in_valid ? flags_wb  : '0;
            d1_q     <= flags_deco ? rdata_a : '0;
            d2_q     <= flags_deco ? rdata_b : '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign out_valid     = valid_q;
    assign pc1_out       = pc1_q;
    assign opcode_out    = opcode_q;
    assign immediate_out = imm_q;
    assign rd_out        = rd_q;
    assign flags_alu_out = falu_q;
    assign flags_mem_out = fmem_q;
    assign flags_wb_out  = fwb_q;
    assign data_one      = d1_q;
    assign data_two      = d2_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: a reference model of the ID stage feeds an expected-output queue,
// plus directed scenario checks; a second instance with a 2-bit counter shows saturation.
module tb_decode_stage_pipe;

    localparam int PW = 165;

    logic        clk = 1'b0;
    logic        rst, in_valid, uses_rt, flags_deco, wb_we, flush;
    logic [47:0] pc1;
    logic [5:0]  opcode;
    logic [4:0]  rd, rs, rt, wb_dir, dbg_addr;
    logic [31:0] immediate, wb_data;
    logic [3:0]  flags_alu;
    logic [2:0]  flags_mem;
    logic [1:0]  flags_wb;

    logic        stall, out_valid;
    logic [47:0] pc1_out;
    logic [5:0]  opcode_out;
    logic [31:0] immediate_out, data_one, data_two, dbg_data;
    logic [4:0]  rd_out;
    logic [3:0]  flags_alu_out;
    logic [2:0]  flags_mem_out;
    logic [1:0]  flags_wb_out;
    logic [15:0] stall_cnt;

    logic        stall2, out_valid2;
    logic [47:0] pc1_out2;
    logic [5:0]  opcode_out2;
    logic [31:0] immediate_out2, data_one2, data_two2, dbg_data2;
    logic [4:0]  rd_out2;
    logic [3:0]  flags_alu_out2;
    logic [2:0]  flags_mem_out2;
    logic [1:0]  flags_wb_out2;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] exp_q[$];

    // reference model state
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [47:0] m_pc;
    logic [5:0]  m_opc;
    logic [31:0] m_imm, m_d1, m_d2;
    logic [4:0]  m_rd;
    logic [3:0]  m_falu;
    logic [2:0]  m_fmem;
    logic [1:0]  m_fwb;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc1(pc1), .opcode(opcode),
        .rd(rd), .rs(rs), .rt(rt), .uses_rt(uses_rt), .immediate(immediate),
        .flags_deco(flags_deco), .flags_alu(flags_alu), .flags_mem(flags_mem),
        .flags_wb(flags_wb), .wb_dir(wb_dir), .wb_data(wb_data), .wb_we(wb_we),
        .flush(flush), .stall(stall), .out_valid(out_valid), .pc1_out(pc1_out),
        .opcode_out(opcode_out), .immediate_out(immediate_out), .rd_out(rd_out),
        .flags_alu_out(flags_alu_out), .flags_mem_out(flags_mem_out),
        .flags_wb_out(flags_wb_out), .data_one(data_one), .data_two(data_two),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .stall_cnt(stall_cnt)
    );

    decode_stage_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc1(pc1), .opcode(opcode),
        .rd(rd), .rs(rs), .rt(rt), .uses_rt(uses_rt), .immediate(immediate),
        .flags_deco(flags_deco), .flags_alu(flags_alu), .flags_mem(flags_mem),
        .flags_wb(flags_wb), .wb_dir(wb_dir), .wb_data(wb_data), .wb_we(wb_we),
        .flush(flush), .stall(stall2), .out_valid(out_valid2), .pc1_out(pc1_out2),
        .opcode_out(opcode_out2), .immediate_out(immediate_out2), .rd_out(rd_out2),
        .flags_alu_out(flags_alu_out2), .flags_mem_out(flags_mem_out2),
        .flags_wb_out(flags_wb_out2), .data_one(data_one2), .data_two(data_two2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data2), .stall_cnt(stall_cnt2)
    );

    function automatic logic [31:0] m_read(input logic [4:0] addr);
        if (addr == 5'd0)                   return 32'd0;
        if (wb_we && (wb_dir == addr))      return wb_data;
        return m_rf[addr];
    endfunction

    task automatic drive_idle();
        rst = 1'b0; in_valid = 1'b0; uses_rt = 1'b0; flags_deco = 1'b0; wb_we = 1'b0;
        flush = 1'b0; pc1 = '0; opcode = '0; rd = '0; rs = '0; rt = '0;
        immediate = '0; flags_alu = '0; flags_mem = '0; flags_wb = '0;
        wb_dir = '0; wb_data = '0; dbg_addr = '0;
    endtask

    task automatic drive_instr(input logic [47:0] p, input logic [4:0] d, input logic [4:0] s,
                               input logic [4:0] t, input logic ur, input logic [2:0] fm);
        in_valid = 1'b1; pc1 = p; opcode = p[5:0] ^ 6'h2A; rd = d; rs = s; rt = t;
        uses_rt = ur; immediate = {p[15:0], p[15:0]}; flags_deco = 1'b1;
        flags_alu = p[3:0] | 4'h1; flags_mem = fm; flags_wb = 2'b01;
    endtask

    // One clock: model the edge, push the expectation, then compare after the edge.
    task automatic cycle();
        logic          m_haz, m_stall;
        logic [31:0]   exp_dbg;
        logic [PW-1:0] exp_v, got_v;
        #1;
        m_haz   = in_valid && m_valid && m_fmem[0] && (m_rd != 0) &&
                  ((m_rd == rs) || (uses_rt && (m_rd == rt)));
        m_stall = m_haz && !flush && !rst;
        exp_dbg = m_read(dbg_addr);
        checks++;
        if (stall !== m_stall) begin
            errors++;
            $display("FAIL stall: got %b expected %b at %0t", stall, m_stall, $time);
        end
        checks++;
        if (dbg_data !== exp_dbg) begin
            errors++;
            $display("FAIL dbg_data: got %h expected %h at %0t", dbg_data, exp_dbg, $time);
        end
        if (rst || flush || m_stall) begin
            m_valid = 0; m_pc = 0; m_opc = 0; m_imm = 0; m_rd = 0;
            m_falu = 0; m_fmem = 0; m_fwb = 0; m_d1 = 0; m_d2 = 0;
        end else begin
            m_valid = in_valid; m_pc = pc1; m_opc = opcode; m_imm = immediate; m_rd = rd;
            m_falu = in_valid ? flags_alu : 4'd0;
            m_fmem = in_valid ? flags_mem : 3'd0;
            m_fwb  = in_valid ? flags_wb  : 2'd0;
            m_d1 = flags_deco ? m_read(rs) : 32'd0;
            m_d2 = flags_deco ? m_read(rt) : 32'd0;
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (wb_we && (wb_dir != 0)) m_rf[wb_dir] = wb_data;
            if (m_stall && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 1;
            if (m_stall && (m_cnt2 != 2'd3))    m_cnt2 = m_cnt2 + 1;
        end
        exp_q.push_back({m_valid, m_pc, m_opc, m_imm, m_rd, m_falu, m_fmem, m_fwb, m_d1, m_d2});
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        got_v = {out_valid, pc1_out, opcode_out, immediate_out, rd_out, flags_alu_out,
                 flags_mem_out, flags_wb_out, data_one, data_two};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL idex: got %h expected %h at %0t", got_v, exp_v, $time);
        end
        checks++;
        if ((stall_cnt !== m_cnt) || (stall_cnt2 !== m_cnt2)) begin
            errors++;
            $display("FAIL stall_cnt: got %0d/%0d expected %0d/%0d at %0t",
                     stall_cnt, stall_cnt2, m_cnt, m_cnt2, $time);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ((out_valid !== 1'b0) || (stall_cnt !== 16'd0) || (data_one !== 32'd0)) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b cnt=%0d d1=%h expected 0", out_valid, stall_cnt, data_one);
        end
        drive_idle();
        wb_we = 1'b1; wb_dir = 5'd7; wb_data = 32'h0000_0055;
        cycle();
        drive_instr(48'h1000, 5'd2, 5'd7, 5'd1, 1'b1, 3'b000);
        wb_we = 1'b1; wb_dir = 5'd9; wb_data = 32'h0000_0099;
        rst = 1'b1;
        cycle();
        drive_idle();
        dbg_addr = 5'd9;
        #1;
        checks++;
        if ((dbg_data !== 32'd0) || (out_valid !== 1'b0) || (pc1_out !== 48'd0)) begin
            errors++;
            $display("FAIL reset_mid: got r9=%h v=%b pc=%h expected 0", dbg_data, out_valid, pc1_out);
        end
        dbg_addr = 5'd7;
        cycle();
    endtask

    task automatic test_bypass();
        drive_idle();
        drive_instr(48'h2000, 5'd4, 5'd3, 5'd0, 1'b0, 3'b000);
        wb_we = 1'b1; wb_dir = 5'd3; wb_data = 32'hDEAD_BEEF;
        cycle();
        checks++;
        if (data_one !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass: got %h expected deadbeef", data_one);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_instr(48'h3000, 5'd5, 5'd1, 5'd2, 1'b1, 3'b001);
        cycle();
        drive_instr(48'h3004, 5'd6, 5'd5, 5'd2, 1'b1, 3'b000);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: got %b expected 1", stall);
        end
        cycle();
        checks++;
        if ((out_valid !== 1'b0) || (flags_mem_out !== 3'd0) || (stall_cnt !== 16'd1)) begin
            errors++;
            $display("FAIL load_use_bubble: got v=%b fm=%0d cnt=%0d expected 0/0/1",
                     out_valid, flags_mem_out, stall_cnt);
        end
        cycle();
        checks++;
        if ((out_valid !== 1'b1) || (pc1_out !== 48'h3004)) begin
            errors++;
            $display("FAIL load_use_issue: got v=%b pc=%h expected 1/3004", out_valid, pc1_out);
        end
        drive_instr(48'h3008, 5'd5, 5'd1, 5'd2, 1'b1, 3'b001);
        cycle();
        drive_instr(48'h300C, 5'd6, 5'd1, 5'd5, 1'b0, 3'b000);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_rt_unused: got %b expected 0", stall);
        end
        cycle();
    endtask

    task automatic test_flush_hazard();
        logic [15:0] cnt_before;
        drive_instr(48'h4000, 5'd6, 5'd1, 5'd2, 1'b1, 3'b001);
        cycle();
        cnt_before = stall_cnt;
        drive_instr(48'h4004, 5'd8, 5'd6, 5'd2, 1'b1, 3'b000);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %b expected 0", stall);
        end
        cycle();
        flush = 1'b0;
        checks++;
        if ((out_valid !== 1'b0) || (stall_cnt !== cnt_before)) begin
            errors++;
            $display("FAIL flush_bubble: got v=%b cnt=%0d expected 0/%0d", out_valid, stall_cnt, cnt_before);
        end
    endtask

    task automatic test_zero_reg();
        drive_idle();
        drive_instr(48'h5000, 5'd1, 5'd0, 5'd0, 1'b1, 3'b000);
        wb_we = 1'b1; wb_dir = 5'd0; wb_data = 32'h0000_1234;
        dbg_addr = 5'd0;
        #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL zero_dbg: got %h expected 0", dbg_data);
        end
        cycle();
        checks++;
        if (data_one !== 32'd0) begin
            errors++;
            $display("FAIL zero_read: got %h expected 0", data_one);
        end
        drive_idle();
        drive_instr(48'h5004, 5'd0, 5'd1, 5'd1, 1'b1, 3'b001);
        cycle();
        drive_instr(48'h5008, 5'd2, 5'd0, 5'd0, 1'b1, 3'b000);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_load_stall: got %b expected 0", stall);
        end
        cycle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_instr(48'h6000 + 48'(k * 16), 5'd4, 5'd1, 5'd1, 1'b0, 3'b001);
            cycle();
            drive_instr(48'h6008 + 48'(k * 16), 5'd7, 5'd4, 5'd1, 1'b0, 3'b000);
            cycle();
            drive_idle();
            cycle();
        end
        checks++;
        if ((stall_cnt2 !== 2'd3) || (stall_cnt !== 16'd5)) begin
            errors++;
            $display("FAIL saturation: got %0d/%0d expected 3/5", stall_cnt2, stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [63:0] r64;
        for (int n = 0; n < 300; n++) begin
            r64 = {$urandom(), $urandom()};
            drive_instr(r64[47:0], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        3'($urandom_range(0, 7)));
            in_valid   = ($urandom_range(0, 7) != 0);
            flags_deco = ($urandom_range(0, 5) != 0);
            flags_wb   = 2'($urandom_range(0, 3));
            wb_we      = 1'($urandom_range(0, 1));
            wb_dir     = 5'($urandom_range(0, 7));
            wb_data    = $urandom();
            flush      = ($urandom_range(0, 7) == 0);
            dbg_addr   = 5'($urandom_range(0, 8));
            cycle();
        end
        drive_idle();
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_valid = 0; m_pc = 0; m_opc = 0; m_imm = 0; m_rd = 0;
        m_falu = 0; m_fmem = 0; m_fwb = 0; m_d1 = 0; m_d2 = 0;
        m_cnt = 0; m_cnt2 = 0;
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_load_use();
        test_flush_hazard();
        test_zero_reg();
        test_saturation();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
